// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore sequencer for fetch, decode, memory,
// R-type, branch and jump instructions, with a memory wait watchdog that
// parks the machine in HALT when MemReady stays low too long.
// Optional feature macro: MIPS_MC_ADDI_EN adds the ADDIEX/ADDIWB states for addi.
module mips_mc_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCEn,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] State,
  output logic       IllegalOp,
  output logic       MemErr
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
`ifdef MIPS_MC_ADDI_EN
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
`endif
    StJump   = 4'd11,
    StHalt   = 4'd15
  } state_e;

  localparam logic [8:0] WaitLimit = 9'(WAIT_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_err_q, mem_err_d;
  logic       wait_hit;
  logic       in_mem;
  logic       op_illegal;

  // Funct only feeds the ALU decoder outside this block.
  logic unused_funct;
  assign unused_funct = ^Funct;

  // Next-state, wait counter and sticky error computation.
  always_comb begin
    state_d    = state_q;
    op_illegal = 1'b0;
    // This cycle's low MemReady would be the WAIT_LIMIT-th consecutive one.
    wait_hit   = (({1'b0, wait_q} + 9'd1) >= WaitLimit);

    case (state_q)
      StFetch: begin
        if (MemReady)      state_d = StDecode;
        else if (wait_hit) state_d = StHalt;
      end
      StDecode: begin
        case (Op)
          6'b100011, 6'b101011: state_d = StMemAdr;
          6'b000000:            state_d = StExec;
          6'b000100:            state_d = StBranch;
          6'b000010:            state_d = StJump;
`ifdef MIPS_MC_ADDI_EN
          6'b001000:            state_d = StAddiEx;
`endif
          default: begin
            state_d    = StFetch;
            op_illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (Op == 6'b100011) ? StMemRd : StMemWr;
      StMemRd: begin
        if (MemReady)      state_d = StMemWb;
        else if (wait_hit) state_d = StHalt;
      end
      StMemWb: state_d = StFetch;
      StMemWr: begin
        if (MemReady)      state_d = StFetch;
        else if (wait_hit) state_d = StHalt;
      end
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
`ifdef MIPS_MC_ADDI_EN
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
`endif
      StJump:   state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase

    // Counter runs only while waiting in place; any entry or exit clears it.
    in_mem = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    wait_d = 8'd0;
    if (in_mem && !MemReady && (state_d == state_q)) begin
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    end

    mem_err_d = mem_err_q | (state_d == StHalt);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StFetch;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Per-state datapath strobes; everything not named for a state stays 0.
  always_comb begin
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    PCEn      = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    IllegalOp = 1'b0;

    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR load and PC+4 commit only on the cycle the fetch completes.
        IRWrite = MemReady;
        PCEn    = MemReady;
      end
      StDecode: begin
        ALUSrcB   = 2'b11;
        IllegalOp = op_illegal;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCEn    = Zero;
      end
`ifdef MIPS_MC_ADDI_EN
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: RegWrite = 1'b1;
`endif
      StJump: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
  end

  assign State  = state_q;
  assign MemErr = mem_err_q;

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 15: consecutive MemReady-low cycles in a memory state that trip MemErr (range 1..255).
REQ-002 Clk  in  1  system clock; all state changes on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Op  in  6  instruction[31:26] from the instruction register; Funct  in  6  instruction[5:0].
REQ-005 Zero  in  1  ALU zero flag; MemReady  in  1  RAM access complete this cycle.
REQ-006 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn  out  1 each  datapath strobes and selects.
REQ-007 ALUSrcB  out  2, ALUOp  out  2, PCSrc  out  2  datapath mux selects.
REQ-008 State  out  4  current state code; IllegalOp  out  1  one-cycle pulse; MemErr  out  1  sticky error.

Function
REQ-009 The block SHALL be a Moore FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=15.
REQ-010 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite and PCEn SHALL be 1 only in the cycle MemReady=1, then go to DECODE; else stay in FETCH.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by Op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX (REQ-026), otherwise FETCH with IllegalOp=1 for that cycle.
REQ-012 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op=100011 -> MEMRD, else MEMWR.
REQ-013 MEMRD: MemRead=1, IorD=1; MemReady=1 -> MEMWB, else stay.
REQ-014 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; -> FETCH.
REQ-015 MEMWR: MemWrite=1, IorD=1; MemReady=1 -> FETCH, else stay; MemWrite held high throughout the wait.
REQ-016 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero; -> FETCH.
REQ-018 JUMP: PCSrc=10, PCEn=1; -> FETCH.
REQ-019 All outputs not listed for a state SHALL be 0; ALUSrcB/ALUOp/PCSrc default 00.
REQ-020 An internal wait counter SHALL clear on entry to and on leaving any of FETCH/MEMRD/MEMWR, and increment (saturating) each cycle MemReady=0 in those states.
REQ-021 When the counter reaches WAIT_LIMIT with MemReady still 0, next state SHALL be HALT and MemErr SHALL go 1; MemReady=1 on that same cycle takes priority (normal transition, no error).
REQ-022 HALT: all strobes 0, MemErr=1, stays in HALT until Reset.
REQ-023 Funct SHALL be ignored by sequencing (ALU decoder uses it); no state depends on Funct.
REQ-024 Cycle counts with MemReady always 1: R-type 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-025 Reset low SHALL immediately force State=FETCH, wait counter=0, MemErr=0, IllegalOp=0, at any point including mid-access or in HALT; FETCH strobes resume from the first rising Clk after Reset returns high.

Configuration
REQ-026 Macro MIPS_MC_ADDI_EN: defined -> Op=001000 goes DECODE -> ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00) -> ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0) -> FETCH, 4 cycles; undefined -> states 9/10 absent and Op=001000 is illegal per REQ-011.

Verification
REQ-027 Reset low mid-MEMRD, then high -> State=0 immediately, MemErr=0, next fetch completes normally.
REQ-028 R-type Op=000000, MemReady=1 -> State 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
REQ-029 lw Op=100011, MemReady low 3 cycles in MEMRD -> State 0,1,2,3,3,3,3,4,0; MemRead stays 1 in all state-3 cycles.
REQ-030 beq Op=000100 with Zero=1, then Zero=0 -> PCEn=1 in state 8 first time, 0 second time.
REQ-031 WAIT_LIMIT=4, MemReady held 0 in FETCH -> HALT after 4 wait cycles, MemErr=1, stays HALT until Reset; variant with MemReady=1 on 4th cycle -> DECODE, MemErr=0.
REQ-032 Op=001000 -> with MIPS_MC_ADDI_EN: State 0,1,9,10,0; without: State 0,1,0 with IllegalOp=1 in the DECODE cycle.
